// File: rtl/serial_word_tx_pkg.sv
// Shared state encoding for the serial word transmitter.
// 2'b11 is unused; the FSM steers it back to idle on the next edge.
package serial_word_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/serial_word_tx_bit_down_counter.sv
// Loadable down counter with zero flag; load wins over decrement.
// Decrement saturates at zero so the count never wraps.
module bit_down_counter #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-in serial-out transmitter: MSB first on D_out with E_out strobe, one cycle after accept.
// No backpressure: start is taken only in idle, otherwise dropped; one word per WIDTH+2 cycles.
module serial_word_tx
   import serial_word_tx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic             D_out,
   output logic             E_out,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             d_out_q, d_out_d;
   logic             e_out_q, e_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cnt_load, cnt_dec, cnt_zero;

   bit_down_counter #(
      .CNT_W(CNT_W)
   ) u_bit_cnt (
      .clk     (clk),
      .reset   (reset),
      .load    (cnt_load),
      .load_val(CNT_W'(WIDTH - 1)),
      .dec     (cnt_dec),
      .zero    (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shreg_d  = data_in;
               cnt_load = 1'b1;
               state_d  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shreg_d = shreg_q << 1;
            cnt_dec = 1'b1;
            if (cnt_zero) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            shreg_d = '0;
         end
      endcase

      // Outputs are registered from the next state so they line up with it (Moore).
      e_out_d = (state_d == ST_SHIFT);
      d_out_d = (state_d == ST_SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
      busy_d  = (state_d == ST_SHIFT) || (state_d == ST_DONE);
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         d_out_q <= 1'b0;
         e_out_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         d_out_q <= d_out_d;
         e_out_q <= e_out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign D_out = d_out_q;
   assign E_out = e_out_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: directed words, expected bits and words queued at issue,
// checked by a negedge monitor fed through an 8-stage enabled-flop receiver chain.
module tb_serial_word_tx;

   localparam int WIDTH      = 8;
   localparam int CLK_PERIOD = 20;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] data_in;
   logic             D_out;
   logic             E_out;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] chain;

   logic             exp_bits[$];
   logic [WIDTH-1:0] exp_words[$];

   int n_cmp = 0;
   int n_err = 0;

   always #(CLK_PERIOD / 2) clk = ~clk;

   serial_word_tx #(
      .WIDTH(WIDTH),
      .CNT_W(5)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .data_in(data_in),
      .D_out  (D_out),
      .E_out  (E_out),
      .busy   (busy),
      .done   (done)
   );

   // Receiver: chain of D flops that shift in D_out whenever E_out is high.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         chain <= '0;
      end else if (E_out) begin
         chain <= {chain[WIDTH-2:0], D_out};
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h, t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input logic [WIDTH-1:0] w);
      for (int i = WIDTH - 1; i >= 0; i--) exp_bits.push_back(w[i]);
      exp_words.push_back(w);
   endtask

   // Monitor: pops an expected bit on every strobe, an expected word on every done pulse.
   always @(negedge clk) begin
      chk("busy_is_shift_or_done", busy, E_out | done);
      chk("no_strobe_during_done", E_out & done, 1'b0);
      if (E_out) begin
         chk("bit_pending_at_strobe", exp_bits.size() > 0, 1'b1);
         if (exp_bits.size() > 0) chk("serial_bit", D_out, exp_bits.pop_front());
      end else begin
         chk("d_zero_without_strobe", D_out, 1'b0);
      end
      if (done) begin
         chk("word_pending_at_done", exp_words.size() > 0, 1'b1);
         if (exp_words.size() > 0) chk("loopback_word", chain, exp_words.pop_front());
      end
   end

   // Caller sits 1 time unit after a rising edge; returns in the first SHIFT cycle.
   task automatic accept(input logic [WIDTH-1:0] w);
      start   = 1'b1;
      data_in = w;
      push_word(w);
      @(posedge clk); #1;
      start = 1'b0;
      chk("accept_latency_e", E_out, 1'b1);
      chk("first_bit_msb", D_out, w[WIDTH-1]);
      chk("busy_on_accept", busy, 1'b1);
   endtask

   task automatic finish_word(input int start_cnt, input bit poke_done);
      int cnt;
      bit seen;
      cnt  = start_cnt;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (E_out) begin
            cnt++;
         end else begin
            seen = 1'b1;
            break;
         end
      end
      chk("word_end_within_budget", seen, 1'b1);
      chk("strobe_cycles", cnt, WIDTH);
      chk("done_pulse", done, 1'b1);
      chk("busy_in_done", busy, 1'b1);
      if (poke_done) begin
         start   = 1'b1;
         data_in = 8'h3C;
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_one_cycle", done, 1'b0);
      chk("busy_released", busy, 1'b0);
      chk("idle_no_strobe", E_out, 1'b0);
   endtask

   initial begin
      int  k;
      bit  seen_done;

      // 1. reset state, and idle hold with start low
      reset   = 1'b1;
      start   = 1'b0;
      data_in = '0;
      #12;
      chk("rst_d_out", D_out, 1'b0);
      chk("rst_e_out", E_out, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      reset = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("idle_hold_e", E_out, 1'b0);
         chk("idle_hold_busy", busy, 1'b0);
         chk("idle_hold_done", done, 1'b0);
      end

      // 2. single word A5
      accept(8'hA5);
      finish_word(1, 1'b0);

      // 3. loopback with data_in disturbed during SHIFT
      accept(8'hA5);
      repeat (2) begin
         @(posedge clk); #1;
      end
      data_in = 8'hFF;
      finish_word(3, 1'b0);
      chk("chain_after_word", chain, 8'hA5);

      // 4. start pulses during SHIFT and DONE are dropped
      accept(8'h96);
      start   = 1'b1;
      data_in = 8'h3C;
      @(posedge clk); #1;
      start = 1'b0;
      finish_word(2, 1'b1);
      repeat (2) begin
         @(posedge clk); #1;
         chk("no_second_word", busy, 1'b0);
      end

      // 5. back-to-back with start held high
      accept(8'h81);
      start     = 1'b1;
      k         = 0;
      seen_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         k++;
         if (done && !seen_done) begin
            seen_done = 1'b1;
            data_in   = 8'h7E;
            push_word(8'h7E);
         end else if (E_out && seen_done) begin
            break;
         end
      end
      start = 1'b0;
      chk("accept_spacing", k, WIDTH + 2);
      chk("second_first_bit", D_out, 1'b0);
      finish_word(1, 1'b0);

      // 6. reset in the 4th SHIFT cycle, reset beats start, then a clean word
      accept(8'hF0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      #3;
      reset = 1'b1;
      #1;
      chk("async_rst_e", E_out, 1'b0);
      chk("async_rst_d", D_out, 1'b0);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_done", done, 1'b0);
      exp_bits.delete();
      exp_words.delete();
      start   = 1'b1;
      data_in = 8'h55;
      @(posedge clk); #1;
      chk("reset_beats_start", busy, 1'b0);
      start = 1'b0;
      reset = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("no_done_after_abort", done, 1'b0);
         chk("idle_after_abort", busy, 1'b0);
      end
      accept(8'h0F);
      finish_word(1, 1'b0);
      chk("chain_after_abort", chain, 8'h0F);

      @(posedge clk); #1;
      chk("bits_drained", exp_bits.size(), 0);
      chk("words_drained", exp_words.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #(CLK_PERIOD * 5000);
      $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-in, serial-out transmitter; the driving end of the D/E single-bit capture interface.
- Loads a WIDTH-bit word on a start pulse.
- Presents the word one bit per clock on D_out with enable strobe E_out, MSB first, so a chain of enabled D flip-flops can capture it.
- Reports busy/done to the issuing controller.

Parameters:
- WIDTH, 8, number of bits per word; legal range 2..32.
- CNT_W, 5, width of the bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE and clears all outputs.
- start  input  1  request to transmit data_in; sampled on the rising edge.
- data_in  input  WIDTH  word to send; sampled only on the accepting edge.
- D_out  output  1  current serial bit.
- E_out  output  1  bit-valid strobe; downstream capture flop loads D_out when E_out=1.
- busy  output  1  high from the accepting edge until the edge that returns the FSM to IDLE.
- done  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset (asynchronous, any time, including mid-word):
  - state=IDLE, shift register=0, counter=0.
  - D_out=0, E_out=0, busy=0, done=0.
  - Deassertion takes effect at the next rising edge.
- FSM states: IDLE, SHIFT, DONE. Outputs are registered (Moore).
- IDLE:
  - E_out=0, D_out=0, busy=0, done=0.
  - start=1 at a rising edge: load shreg<=data_in, counter<=WIDTH-1, go to SHIFT.
  - Acceptance latency: D_out carries data_in[WIDTH-1] with E_out=1 in the first cycle after the accepting edge.
- SHIFT:
  - E_out=1, busy=1, D_out=shreg[WIDTH-1].
  - Each edge: shreg<=shreg<<1 (LSB filled with 0), counter<=counter-1.
  - Edge with counter==0: go to DONE.
  - E_out is therefore high for exactly WIDTH consecutive cycles, bits in order data_in[WIDTH-1] down to data_in[0].
- DONE:
  - E_out=0, D_out=0, busy=1, done=1 for exactly one cycle.
  - Next edge: go to IDLE unconditionally.
- start while SHIFT or DONE: ignored, not queued. data_in changes after acceptance have no effect.
- Back-to-back words: start held high continuously gives one word every WIDTH+2 cycles (WIDTH shift, 1 DONE, 1 IDLE accept).
- No wrap-around: the counter never decrements below 0; the SHIFT exit occurs on the counter==0 edge.
- Reset during SHIFT: E_out drops immediately (asynchronously). The partial word is discarded and no done pulse is issued.
- reset and start asserted together: reset wins, no load.

Decomposition:
- Shared include file holds the state-encoding localparams: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10. Encoding 2'b11 is illegal and recovers to IDLE on the next edge.
- One natural sub-module: bit_down_counter (CNT_W-bit, synchronous load and decrement-enable, asynchronous active-high reset, zero flag output).
- The shift register and FSM stay in serial_word_tx.

Test Plan (WIDTH=8, CLK_PERIOD=20):
1. Reset: reset=1 for 10 time units -> D_out=0, E_out=0, busy=0, done=0. Release reset, start=0 for 3 cycles -> outputs unchanged.
2. Single word: data_in=8'hA5, start=1 for one edge -> next 8 cycles E_out=1 with D_out sequence 1,0,1,0,0,1,0,1; busy=1 throughout; then one cycle done=1, E_out=0; then busy=0.
3. Receiver loopback: D_out/E_out feed an 8-stage chain of enabled D flops (shift on E) -> after done, chain holds 8'hA5. data_in changed to 8'hFF at cycle 3 of SHIFT -> chain still 8'hA5.
4. Ignored start: pulse start with data_in=8'h3C during SHIFT and during DONE -> transmitted bits unchanged, no second word begins, busy falls after the DONE cycle.
5. Back-to-back: start held 1, data_in=8'h81 then 8'h7E at the second accept -> streams 1000_0001 and 0111_1110, each followed by done pulse, accepts spaced 10 cycles.
6. Reset mid-word: assert reset during the 4th SHIFT cycle of 8'hF0 -> E_out, D_out, busy fall immediately without waiting for the edge, no done pulse. After release, start with 8'h0F -> clean 0000_1111 transmission.
